// File: rtl/ring_monitor.sv
// One-hot rotating ring code monitor: checks legality and single-step rotation,
// decodes the hot-bit position, locks after a run of good steps and flags errors while locked.
module ring_monitor #(
   parameter int WIDTH    = 4,
   parameter int LOCK_CNT = 4,
   parameter int ERR_W    = 8,
   localparam int POS_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] ring_in,
   input  logic             sample_en,
   input  logic             clr_err,
   output logic [POS_W-1:0] pos,
   output logic             pos_valid,
   output logic             locked,
   output logic             err,
   output logic [ERR_W-1:0] err_count
);

   localparam int GC_W = $clog2(LOCK_CNT + 1);

   typedef enum logic [1:0] {HUNT, TRACK, LOCKED} state_t;

   state_t            state_reg, state_next;
   logic [GC_W-1:0]   good_cnt_reg, good_cnt_next;
   logic [WIDTH-1:0]  prev_reg, prev_next;
   logic [POS_W-1:0]  pos_reg, pos_next;
   logic              pos_valid_reg, pos_valid_next;
   logic              locked_reg, locked_next;
   logic              err_reg, err_next;
   logic [ERR_W-1:0]  err_count_reg, err_count_next;

   logic [POS_W-1:0]  idx_terms [WIDTH];
   logic [POS_W-1:0]  hot_index;
   logic [WIDTH-1:0]  expected;
   logic              legal;
   logic              step_ok;

   // Each bit contributes its own index when hot; OR-ing is exact for one-hot words.
   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_idx
         assign idx_terms[gi] = ring_in[gi] ? POS_W'(gi) : '0;
      end
   endgenerate

   always_comb begin
      hot_index = '0;
      for (int i = 0; i < WIDTH; i++) begin
         hot_index = hot_index | idx_terms[i];
      end
   end

   assign legal    = (ring_in != '0) && ((ring_in & (ring_in - WIDTH'(1))) == '0);
   assign expected = {prev_reg[WIDTH-2:0], prev_reg[WIDTH-1]};
   assign step_ok  = legal && (ring_in == expected);

   always_comb begin
      state_next     = state_reg;
      good_cnt_next  = good_cnt_reg;
      prev_next      = prev_reg;
      pos_next       = pos_reg;
      pos_valid_next = pos_valid_reg;
      locked_next    = locked_reg;
      err_next       = 1'b0;
      err_count_next = err_count_reg;

      if (sample_en) begin
         pos_valid_next = legal;
         pos_next       = legal ? hot_index : '0;
         if (legal) begin
            prev_next = ring_in;
         end

         case (state_reg)
            HUNT: begin
               if (legal) begin
                  state_next    = TRACK;
                  good_cnt_next = '0;
               end
            end
            TRACK: begin
               if (step_ok) begin
                  if (good_cnt_reg == GC_W'(LOCK_CNT - 1)) begin
                     state_next    = LOCKED;
                     locked_next   = 1'b1;
                     good_cnt_next = GC_W'(LOCK_CNT);
                  end else begin
                     good_cnt_next = good_cnt_reg + GC_W'(1);
                  end
               end else if (legal) begin
                  // A legal but unexpected word becomes the new reference.
                  good_cnt_next = '0;
               end else begin
                  state_next = HUNT;
               end
            end
            LOCKED: begin
               if (!step_ok) begin
                  err_next      = 1'b1;
                  locked_next   = 1'b0;
                  good_cnt_next = '0;
                  state_next    = legal ? TRACK : HUNT;
                  if (err_count_reg != '1) begin
                     err_count_next = err_count_reg + ERR_W'(1);
                  end
               end
            end
            default: state_next = HUNT;
         endcase
      end

      // Clearing takes priority over a same-edge increment.
      if (clr_err) begin
         err_count_next = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= HUNT;
         good_cnt_reg  <= '0;
         prev_reg      <= '0;
         pos_reg       <= '0;
         pos_valid_reg <= 1'b0;
         locked_reg    <= 1'b0;
         err_reg       <= 1'b0;
         err_count_reg <= '0;
      end else begin
         state_reg     <= state_next;
         good_cnt_reg  <= good_cnt_next;
         prev_reg      <= prev_next;
         pos_reg       <= pos_next;
         pos_valid_reg <= pos_valid_next;
         locked_reg    <= locked_next;
         err_reg       <= err_next;
         err_count_reg <= err_count_next;
      end
   end

   assign pos       = pos_reg;
   assign pos_valid = pos_valid_reg;
   assign locked    = locked_reg;
   assign err       = err_reg;
   assign err_count = err_count_reg;

endmodule

// File: tb/tb_ring_monitor.sv
// Directed bench for ring_monitor: vector table for the main flow plus
// hand-written sequences for saturation, gated sampling and mid-run reset.
module tb_ring_monitor;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] ring_in;
   logic       sample_en;
   logic       clr_err;

   logic [1:0] pos, pos2;
   logic       pos_valid, pos_valid2;
   logic       locked, locked2;
   logic       err, err2;
   logic [7:0] err_count;
   logic [1:0] err_count2;

   int compared   = 0;
   int mismatched = 0;

   ring_monitor #(.WIDTH(4), .LOCK_CNT(4), .ERR_W(8)) dut (
      .clk(clk), .rst(rst), .ring_in(ring_in), .sample_en(sample_en), .clr_err(clr_err),
      .pos(pos), .pos_valid(pos_valid), .locked(locked), .err(err), .err_count(err_count)
   );

   ring_monitor #(.WIDTH(4), .LOCK_CNT(4), .ERR_W(2)) dut2 (
      .clk(clk), .rst(rst), .ring_in(ring_in), .sample_en(sample_en), .clr_err(clr_err),
      .pos(pos2), .pos_valid(pos_valid2), .locked(locked2), .err(err2), .err_count(err_count2)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] ring;
      logic       en;
      logic       clr;
      logic [1:0] xpos;
      logic       xpv;
      logic       xlk;
      logic       xerr;
      logic [7:0] xcnt;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic [3:0] r, input logic e, input logic c,
                               input logic [1:0] p, input logic pv, input logic lk,
                               input logic er, input logic [7:0] cn);
      vec_t v;
      v.ring = r; v.en = e; v.clr = c; v.xpos = p; v.xpv = pv;
      v.xlk = lk; v.xerr = er; v.xcnt = cn;
      return v;
   endfunction

   function automatic logic [1:0] idx(input logic [3:0] w);
      case (w)
         4'b0001: return 2'd0;
         4'b0010: return 2'd1;
         4'b0100: return 2'd2;
         default: return 2'd3;
      endcase
   endfunction

   function automatic logic [3:0] rot(input logic [3:0] w);
      return {w[2:0], w[3]};
   endfunction

   task automatic chk(input string nm, input logic [1:0] xp, input logic xpv,
                      input logic xlk, input logic xer, input logic [7:0] xc);
      logic [1:0] xc2;
      xc2 = (xc > 8'd3) ? 2'd3 : xc[1:0];
      compared++;
      if (pos !== xp || pos_valid !== xpv || locked !== xlk || err !== xer ||
          err_count !== xc || err_count2 !== xc2) begin
         mismatched++;
         $display("FAIL %s: got pos=%0d pv=%0b lk=%0b err=%0b cnt=%0d cnt2=%0d, want pos=%0d pv=%0b lk=%0b err=%0b cnt=%0d cnt2=%0d",
                  nm, pos, pos_valid, locked, err, err_count, err_count2,
                  xp, xpv, xlk, xer, xc, xc2);
      end else begin
         $display("ok   %s: ring=%b en=%0b clr=%0b pos=%0d pv=%0b lk=%0b err=%0b cnt=%0d",
                  nm, ring_in, sample_en, clr_err, pos, pos_valid, locked, err, err_count);
      end
   endtask

   task automatic step(input string nm, input logic [3:0] r, input logic e, input logic c,
                       input logic [1:0] xp, input logic xpv, input logic xlk,
                       input logic xer, input logic [7:0] xc);
      ring_in = r; sample_en = e; clr_err = c;
      @(posedge clk);
      #1;
      chk(nm, xp, xpv, xlk, xer, xc);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #3;
      chk("reset", 2'd0, 1'b0, 1'b0, 1'b0, 8'd0);
      #2;
      rst = 1'b0;
   endtask

   initial begin
      logic [3:0] cur;
      logic [3:0] seq [5];
      logic [1:0] hold_pos;
      logic       hold_lk;

      rst = 1'b1; ring_in = '0; sample_en = 1'b0; clr_err = 1'b0;

      // Basic lock-up sequence
      tbl.push_back(mk(4'b1000, 1, 0, 3, 1, 0, 0, 0));
      tbl.push_back(mk(4'b0001, 1, 0, 0, 1, 0, 0, 0));
      tbl.push_back(mk(4'b0010, 1, 0, 1, 1, 0, 0, 0));
      tbl.push_back(mk(4'b0100, 1, 0, 2, 1, 0, 0, 0));
      tbl.push_back(mk(4'b1000, 1, 0, 3, 1, 1, 0, 0));
      tbl.push_back(mk(4'b0001, 1, 0, 0, 1, 1, 0, 0));
      // Two-hot word while locked, then relock
      tbl.push_back(mk(4'b0110, 1, 0, 0, 0, 0, 1, 1));
      tbl.push_back(mk(4'b0001, 1, 0, 0, 1, 0, 0, 1));
      tbl.push_back(mk(4'b0010, 1, 0, 1, 1, 0, 0, 1));
      tbl.push_back(mk(4'b0100, 1, 0, 2, 1, 0, 0, 1));
      tbl.push_back(mk(4'b1000, 1, 0, 3, 1, 0, 0, 1));
      tbl.push_back(mk(4'b0001, 1, 0, 0, 1, 1, 0, 1));
      // Stuck word, relock, skipped step
      tbl.push_back(mk(4'b0010, 1, 0, 1, 1, 1, 0, 1));
      tbl.push_back(mk(4'b0010, 1, 0, 1, 1, 0, 1, 2));
      tbl.push_back(mk(4'b0100, 1, 0, 2, 1, 0, 0, 2));
      tbl.push_back(mk(4'b1000, 1, 0, 3, 1, 0, 0, 2));
      tbl.push_back(mk(4'b0001, 1, 0, 0, 1, 0, 0, 2));
      tbl.push_back(mk(4'b0010, 1, 0, 1, 1, 1, 0, 2));
      tbl.push_back(mk(4'b0100, 1, 0, 2, 1, 1, 0, 2));
      tbl.push_back(mk(4'b1000, 1, 0, 3, 1, 1, 0, 2));
      tbl.push_back(mk(4'b0001, 1, 0, 0, 1, 1, 0, 2));
      tbl.push_back(mk(4'b0100, 1, 0, 2, 1, 0, 1, 3));
      // Illegal words outside LOCKED never pulse err
      tbl.push_back(mk(4'b0000, 1, 0, 0, 0, 0, 0, 3));
      tbl.push_back(mk(4'b1111, 1, 0, 0, 0, 0, 0, 3));
      // Legal-but-wrong word in TRACK restarts the good-step count
      tbl.push_back(mk(4'b0010, 1, 0, 1, 1, 0, 0, 3));
      tbl.push_back(mk(4'b0100, 1, 0, 2, 1, 0, 0, 3));
      tbl.push_back(mk(4'b0001, 1, 0, 0, 1, 0, 0, 3));
      tbl.push_back(mk(4'b0010, 1, 0, 1, 1, 0, 0, 3));
      tbl.push_back(mk(4'b0100, 1, 0, 2, 1, 0, 0, 3));
      tbl.push_back(mk(4'b1000, 1, 0, 3, 1, 0, 0, 3));
      tbl.push_back(mk(4'b0001, 1, 0, 0, 1, 1, 0, 3));
      // clr_err while sampling is disabled
      tbl.push_back(mk(4'b0110, 0, 1, 0, 1, 1, 0, 0));

      #2;
      chk("reset", 2'd0, 1'b0, 1'b0, 1'b0, 8'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         step($sformatf("vec%0d", i), tbl[i].ring, tbl[i].en, tbl[i].clr,
              tbl[i].xpos, tbl[i].xpv, tbl[i].xlk, tbl[i].xerr, tbl[i].xcnt);
      end

      // Saturation: locked at 0001 with count 0; five stuck-word errors, each followed by relock
      cur = 4'b0001;
      for (int k = 1; k <= 5; k++) begin
         step($sformatf("sat_err%0d", k), cur, 1, 0, idx(cur), 1, 0, 1, 8'(k));
         for (int j = 0; j < 4; j++) begin
            cur = rot(cur);
            step($sformatf("sat_relock%0d_%0d", k, j), cur, 1, 0, idx(cur), 1, (j == 3), 0, 8'(k));
         end
      end
      step("clr_with_err", cur, 1, 1, idx(cur), 1, 0, 1, 8'd0);
      for (int j = 0; j < 4; j++) begin
         cur = rot(cur);
         step($sformatf("relock%0d", j), cur, 1, 0, idx(cur), 1, (j == 3), 0, 8'd0);
      end

      // Asynchronous reset between edges while locked
      #3;
      rst = 1'b1;
      #1;
      chk("async_rst", 2'd0, 1'b0, 1'b0, 1'b0, 8'd0);
      #2;
      rst = 1'b0;
      step("post_rst0", 4'b0100, 1, 0, 2, 1, 0, 0, 0);
      step("post_rst1", 4'b1000, 1, 0, 3, 1, 0, 0, 0);
      step("post_rst2", 4'b0001, 1, 0, 0, 1, 0, 0, 0);
      step("post_rst3", 4'b0010, 1, 0, 1, 1, 0, 0, 0);
      step("post_rst4", 4'b0100, 1, 0, 2, 1, 1, 0, 0);

      // Sampling only every third cycle; garbage in between must be ignored
      @(negedge clk);
      do_reset();
      seq[0] = 4'b1000; seq[1] = 4'b0001; seq[2] = 4'b0010; seq[3] = 4'b0100; seq[4] = 4'b1000;
      for (int i = 0; i < 5; i++) begin
         hold_pos = idx(seq[i]);
         hold_lk  = (i == 4);
         step($sformatf("gated_en%0d", i), seq[i], 1, 0, hold_pos, 1, hold_lk, 0, 0);
         step($sformatf("gated_hold%0da", i), 4'b0110, 0, 0, hold_pos, 1, hold_lk, 0, 0);
         step($sformatf("gated_hold%0db", i), 4'b0001, 0, 0, hold_pos, 1, hold_lk, 0, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
